afe_spi_multi_writer: RTL and testbench
=======================================

# afe_spi_multi_writer

Parametrised, write-only serial controller driving CHANNEL_COUNT independent attenuator/AFE serial ports (clock, data, latch-enable per channel) from a single system-clock CSR strobe interface. Successor to the fixed two-port AFE serial path on the DSBPM boards: adds selectable channel count, variable word length, programmable bit rate, broadcast writes and error/overrun reporting. Sits in the system-clock domain between the CSR decoder and the AFE_SPI_* pins.

## Interface
- CHANNEL_COUNT, 2, number of independent AFE serial ports.
- DATA_WIDTH, 32, maximum word length in bits.
- CLK_DIV_WIDTH, 8, width of the half-period divider.
- CHANNEL_SEL_WIDTH, 4, width of the channel select field.
- BIT_COUNT_WIDTH, 6, width of the bit-count field; must hold DATA_WIDTH.

- sysClk  in  1  system clock; everything is synchronous to it.
- sysReset_n  in  1  reset; asynchronous and active-low.
- csrStrobe  in  1  single-cycle write request.
- csrData  in  DATA_WIDTH  word; lower bitCount bits are shifted MSB-first.
- csrChannel  in  CHANNEL_SEL_WIDTH  target port index.
- csrBroadcast  in  1  1 = drive all ports identically; csrChannel ignored.
- bitCount  in  BIT_COUNT_WIDTH  bits to shift, legal 1..DATA_WIDTH.
- clkDiv  in  CLK_DIV_WIDTH  half-period D in sysClk cycles; 0 treated as 1.
- errorClear  in  1  clears sticky flags.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- badRequest  out  1  sticky: illegal bitCount or channel index.
- overrun  out  1  sticky: strobe received while busy.
- spiClk  out  CHANNEL_COUNT  serial clock per port.
- spiSdi  out  CHANNEL_COUNT  serial data per port.
- spiLe  out  CHANNEL_COUNT  latch enable per port, active high.

## Operation
- States: IDLE, LOW, HIGH, LATCH, GAP.
- IDLE: on csrStrobe, validate. Illegal if bitCount==0, bitCount>DATA_WIDTH, or (!csrBroadcast and csrChannel>=CHANNEL_COUNT): set badRequest, stay IDLE, no done.
- Legal request: latch csrData, bitCount (N), clkDiv (D, 0->1), channel mask (one-hot or all-ones); go LOW. Inputs are not re-sampled during the transfer.
- LOW: spiClk=0, spiSdi=current bit, D cycles, then HIGH.
- HIGH: spiClk=1, spiSdi held, D cycles; if bits remain, shift and go LOW, else LATCH.
- LATCH: spiClk=0, spiSdi=0, spiLe=1, D cycles, then GAP.
- GAP: all lines 0, D cycles, then IDLE with done pulse.
- Masked-off ports hold spiClk=spiSdi=spiLe=0 throughout.
- csrStrobe while busy: ignored, overrun set; the transfer in progress is unaffected.
- errorClear clears both sticky flags next cycle. If errorClear and a new error occur in the same cycle, the flag stays set.
- Reset, including mid-transfer: immediately IDLE, all outputs 0, no done, and the transfer is abandoned.

## Timing
- All outputs are registered, and all outputs reset to 0.
- Accept at edge t: busy=1 from t+1. First LOW phase starts at t+1.
- Bit k (0 = MSB): LOW occupies cycles t+1+2Dk .. t+2Dk+D; HIGH follows for D cycles. The AFE samples on the rising spiClk edge, and data changes only at the start of LOW.
- LATCH starts at t+1+2DN; GAP starts at t+1+2DN+D.
- busy falls and done=1 for exactly one cycle at t+1+2D(N+1).
- A new strobe is accepted in the done cycle, giving back-to-back transfers with no extra idle cycle.
- Illegal request: badRequest set at t+1; busy never asserts.

## Test plan
- CHANNEL_COUNT=2: write 0xA5 to channel 1 with N=8 and D=2, sampling spiSdi[1] on spiClk[1] rising edges. Expect: bits 1,0,1,0,0,1,0,1; spiLe[1] high for 2 cycles; done at t+37; port 0 lines stay 0.
- Broadcast, N=DATA_WIDTH=32, data 0x8000_0001, D=0. Expect: every port sees identical waveforms with D treated as 1; first and last bits are 1; done at t+67.
- Illegal requests: bitCount=0, then 33, then channel=2 without broadcast. Expect: badRequest=1, no spiClk activity, busy stays 0. Then errorClear -> badRequest=0.
- Strobe issued mid-transfer with different data. Expect: overrun=1; the shifted data is unchanged (the original word); exactly one done.
- Strobe held high from the done cycle. Expect: second transfer accepted on the done cycle and first LOW at the next edge.
- Reset pulsed during the HIGH phase of bit 3. Expect: all outputs 0 asynchronously; busy=0; no done after release; the next write completes normally.

Source files
------------

// File: rtl/afe_spi_multi_writer.sv
// Write-only serial controller for CHANNEL_COUNT AFE/attenuator ports (clock, data, latch enable).
// One word is shifted MSB-first to one port or to all ports at once, at a programmable half-period.
module afe_spi_multi_writer #(
    parameter int CHANNEL_COUNT     = 2,
    parameter int DATA_WIDTH        = 32,
    parameter int CLK_DIV_WIDTH     = 8,
    parameter int CHANNEL_SEL_WIDTH = 4,
    parameter int BIT_COUNT_WIDTH   = 6
) (
    input  logic                         sysClk,
    input  logic                         sysReset_n,
    input  logic                         csrStrobe,
    input  logic [DATA_WIDTH-1:0]        csrData,
    input  logic [CHANNEL_SEL_WIDTH-1:0] csrChannel,
    input  logic                         csrBroadcast,
    input  logic [BIT_COUNT_WIDTH-1:0]   bitCount,
    input  logic [CLK_DIV_WIDTH-1:0]     clkDiv,
    input  logic                         errorClear,
    output logic                         busy,
    output logic                         done,
    output logic                         badRequest,
    output logic                         overrun,
    output logic [CHANNEL_COUNT-1:0]     spiClk,
    output logic [CHANNEL_COUNT-1:0]     spiSdi,
    output logic [CHANNEL_COUNT-1:0]     spiLe
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LATCH = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t                       state_reg, state_next;
    logic [CLK_DIV_WIDTH-1:0]     cnt_reg, cnt_next;
    logic [CLK_DIV_WIDTH-1:0]     div_reg, div_next;
    logic [DATA_WIDTH-1:0]        shift_reg, shift_next;
    logic [BIT_COUNT_WIDTH-1:0]   bits_left_reg, bits_left_next;
    logic [CHANNEL_COUNT-1:0]     mask_reg, mask_next;

    logic [CHANNEL_COUNT-1:0]     spi_clk_reg, spi_clk_next;
    logic [CHANNEL_COUNT-1:0]     spi_sdi_reg, spi_sdi_next;
    logic [CHANNEL_COUNT-1:0]     spi_le_reg, spi_le_next;
    logic                         busy_reg, busy_next;
    logic                         done_reg, done_next;
    logic                         bad_reg, bad_next;
    logic                         overrun_reg, overrun_next;

    logic                         count_bad;
    logic                         channel_bad;
    logic                         req_legal;
    logic                         phase_end;
    logic [BIT_COUNT_WIDTH-1:0]   align_amt;
    logic [CHANNEL_COUNT-1:0]     req_mask;
    logic                         line_clk;
    logic                         line_sdi;
    logic                         line_le;

    // Request validation against the live CSR inputs
    assign count_bad   = (bitCount == '0) || (32'(bitCount) > 32'(DATA_WIDTH));
    assign channel_bad = !csrBroadcast && (32'(csrChannel) >= 32'(CHANNEL_COUNT));
    assign req_legal   = !count_bad && !channel_bad;
    assign align_amt   = BIT_COUNT_WIDTH'(DATA_WIDTH) - bitCount;
    assign phase_end   = (cnt_reg == (div_reg - CLK_DIV_WIDTH'(1)));

    generate
        for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_mask
            assign req_mask[gi] = csrBroadcast || (32'(csrChannel) == 32'(gi));
        end
    endgenerate

    // State and datapath register
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            div_reg       <= '0;
            shift_reg     <= '0;
            bits_left_reg <= '0;
            mask_reg      <= '0;
            spi_clk_reg   <= '0;
            spi_sdi_reg   <= '0;
            spi_le_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            bad_reg       <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            div_reg       <= div_next;
            shift_reg     <= shift_next;
            bits_left_reg <= bits_left_next;
            mask_reg      <= mask_next;
            spi_clk_reg   <= spi_clk_next;
            spi_sdi_reg   <= spi_sdi_next;
            spi_le_reg    <= spi_le_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            bad_reg       <= bad_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Next-state logic; each phase lasts div_reg cycles
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + CLK_DIV_WIDTH'(1);
        div_next       = div_reg;
        shift_next     = shift_reg;
        bits_left_next = bits_left_reg;
        mask_next      = mask_reg;

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (csrStrobe && req_legal) begin
                    state_next     = ST_LOW;
                    // Left-justify the word so the first bit to send is always the top bit
                    shift_next     = csrData << align_amt;
                    bits_left_next = bitCount - BIT_COUNT_WIDTH'(1);
                    mask_next      = req_mask;
                    div_next       = (clkDiv == '0) ? CLK_DIV_WIDTH'(1) : clkDiv;
                end
            end
            ST_LOW: begin
                if (phase_end) begin
                    state_next = ST_HIGH;
                    cnt_next   = '0;
                end
            end
            ST_HIGH: begin
                if (phase_end) begin
                    cnt_next = '0;
                    if (bits_left_reg != '0) begin
                        state_next     = ST_LOW;
                        shift_next     = shift_reg << 1;
                        bits_left_next = bits_left_reg - BIT_COUNT_WIDTH'(1);
                    end else begin
                        state_next = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (phase_end) begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end
            end
            ST_GAP: begin
                if (phase_end) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic: values for the next cycle, so every output leaves a flop
    always_comb begin
        line_clk = 1'b0;
        line_sdi = 1'b0;
        line_le  = 1'b0;
        case (state_next)
            ST_LOW: begin
                line_sdi = shift_next[DATA_WIDTH-1];
            end
            ST_HIGH: begin
                line_clk = 1'b1;
                line_sdi = shift_next[DATA_WIDTH-1];
            end
            ST_LATCH: begin
                line_le = 1'b1;
            end
            default: begin
                line_clk = 1'b0;
            end
        endcase

        busy_next    = (state_next != ST_IDLE);
        done_next    = (state_reg == ST_GAP) && phase_end;
        // A new error in the clearing cycle wins over errorClear
        bad_next     = (bad_reg && !errorClear)
                     || (csrStrobe && (state_reg == ST_IDLE) && !req_legal);
        overrun_next = (overrun_reg && !errorClear)
                     || (csrStrobe && (state_reg != ST_IDLE));
    end

    generate
        for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_lines
            assign spi_clk_next[gi] = line_clk && mask_next[gi];
            assign spi_sdi_next[gi] = line_sdi && mask_next[gi];
            assign spi_le_next[gi]  = line_le  && mask_next[gi];
        end
    endgenerate

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign badRequest = bad_reg;
    assign overrun    = overrun_reg;
    assign spiClk     = spi_clk_reg;
    assign spiSdi     = spi_sdi_reg;
    assign spiLe      = spi_le_reg;

endmodule

// File: tb/tb_afe_spi_multi_writer.sv
// Directed bench for afe_spi_multi_writer: single-port, broadcast, illegal, overrun,
// back-to-back and mid-transfer reset scenarios with hand-computed expectations.
module tb_afe_spi_multi_writer;

    logic        sysClk = 1'b0;
    logic        sysReset_n;
    logic        csrStrobe;
    logic [31:0] csrData;
    logic [3:0]  csrChannel;
    logic        csrBroadcast;
    logic [5:0]  bitCount;
    logic [7:0]  clkDiv;
    logic        errorClear;
    logic        busy;
    logic        done;
    logic        badRequest;
    logic        overrun;
    logic [1:0]  spiClk;
    logic [1:0]  spiSdi;
    logic [1:0]  spiLe;

    int n_checks = 0;
    int n_pass   = 0;

    // Results of the most recent watch_transfer call
    int          mon_done_first;
    int          mon_done_count;
    logic [63:0] mon_bits;
    int          mon_nbits;
    int          mon_le;
    int          mon_other;
    int          mon_differ;
    logic        mon_busy_first;
    logic        mon_busy_inj;
    logic        mon_sdi_inj;

    always #5 sysClk = ~sysClk;

    afe_spi_multi_writer dut (
        .sysClk       (sysClk),
        .sysReset_n   (sysReset_n),
        .csrStrobe    (csrStrobe),
        .csrData      (csrData),
        .csrChannel   (csrChannel),
        .csrBroadcast (csrBroadcast),
        .bitCount     (bitCount),
        .clkDiv       (clkDiv),
        .errorClear   (errorClear),
        .busy         (busy),
        .done         (done),
        .badRequest   (badRequest),
        .overrun      (overrun),
        .spiClk       (spiClk),
        .spiSdi       (spiSdi),
        .spiLe        (spiLe)
    );

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Strobe sampled at edge t; returns #1 into cycle t+1
    task automatic issue(input logic [31:0] data, input logic [3:0] ch, input logic bc,
                         input logic [5:0] nbits, input logic [7:0] div);
        @(negedge sysClk);
        csrData = data; csrChannel = ch; csrBroadcast = bc;
        bitCount = nbits; clkDiv = div; csrStrobe = 1'b1;
        @(posedge sysClk);
        #1 csrStrobe = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge sysClk);
        errorClear = 1'b1;
        @(posedge sysClk);
        #1 errorClear = 1'b0;
    endtask

    // Observe cycles 1..budget after acceptance; optionally strobe again at cycle inject_at
    task automatic watch_transfer(input int port, input int budget, input int inject_at,
                                  input logic [31:0] inject_data);
        logic prev_clk;
        prev_clk       = 1'b0;
        mon_done_first = -1;
        mon_done_count = 0;
        mon_bits       = '0;
        mon_nbits      = 0;
        mon_le         = 0;
        mon_other      = 0;
        mon_differ     = 0;
        mon_busy_first = 1'b0;
        mon_busy_inj   = 1'b0;
        mon_sdi_inj    = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (c > 1) begin
                @(posedge sysClk);
                #1 csrStrobe = 1'b0;
            end
            if (c == 1) mon_busy_first = busy;
            if (c == inject_at + 1) begin
                mon_busy_inj = busy;
                mon_sdi_inj  = spiSdi[port];
            end
            if (spiClk[port] && !prev_clk) begin
                mon_bits = {mon_bits[62:0], spiSdi[port]};
                mon_nbits++;
            end
            prev_clk = spiClk[port];
            if (spiLe[port]) mon_le++;
            if (done) begin
                mon_done_count++;
                if (mon_done_first < 0) mon_done_first = c;
            end
            for (int q = 0; q < 2; q++)
                if (q != port && (spiClk[q] || spiSdi[q] || spiLe[q])) mon_other++;
            if (spiClk[0] != spiClk[1] || spiSdi[0] != spiSdi[1] || spiLe[0] != spiLe[1])
                mon_differ++;
            if (c == inject_at) begin
                csrData   = inject_data;
                csrStrobe = 1'b1;
            end
        end
    endtask

    initial begin
        int activity;
        sysReset_n = 1'b0; csrStrobe = 1'b0; csrData = '0; csrChannel = '0;
        csrBroadcast = 1'b0; bitCount = '0; clkDiv = '0; errorClear = 1'b0;
        repeat (3) @(posedge sysClk);
        #1;
        check_value("reset_outputs", {busy, done, badRequest, overrun, spiClk, spiSdi, spiLe},
                    '0);
        @(negedge sysClk) sysReset_n = 1'b1;

        // Channel 1, 0xA5, N=8, D=2
        issue(32'h0000_00A5, 4'd1, 1'b0, 6'd8, 8'd2);
        watch_transfer(1, 45, -10, '0);
        $display("txn A: bits=0x%0h n=%0d done@%0d", mon_bits, mon_nbits, mon_done_first);
        check_value("a_busy_first", mon_busy_first, 1);
        check_value("a_bits", mon_bits, 64'hA5);
        check_value("a_nbits", mon_nbits, 8);
        check_value("a_le_cycles", mon_le, 2);
        check_value("a_done_cycle", mon_done_first, 37);
        check_value("a_done_count", mon_done_count, 1);
        check_value("a_port0_quiet", mon_other, 0);

        // Broadcast, N=32, D=0 treated as 1
        issue(32'h8000_0001, 4'd0, 1'b1, 6'd32, 8'd0);
        watch_transfer(0, 75, -10, '0);
        $display("txn B: bits=0x%0h n=%0d done@%0d", mon_bits, mon_nbits, mon_done_first);
        check_value("b_bits", mon_bits, 64'h8000_0001);
        check_value("b_nbits", mon_nbits, 32);
        check_value("b_le_cycles", mon_le, 1);
        check_value("b_done_cycle", mon_done_first, 67);
        check_value("b_ports_identical", mon_differ, 0);

        // Illegal requests: N=0, N=33, channel 2 without broadcast
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       issue(32'h1, 4'd0, 1'b0, 6'd0, 8'd1);
                1:       issue(32'h1, 4'd0, 1'b0, 6'd33, 8'd1);
                default: issue(32'h1, 4'd2, 1'b0, 6'd8, 8'd1);
            endcase
            check_value($sformatf("bad%0d_flag", k), badRequest, 1);
            activity = 0;
            for (int c = 0; c < 8; c++) begin
                if (busy || spiClk != 2'b00 || done) activity++;
                @(posedge sysClk);
                #1;
            end
            $display("txn illegal %0d: badRequest=%0b activity=%0d", k, badRequest, activity);
            check_value($sformatf("bad%0d_no_activity", k), activity, 0);
            clear_errors();
            check_value($sformatf("bad%0d_cleared", k), badRequest, 0);
        end

        // Strobe mid-transfer: overrun, original word still shifted
        issue(32'h0000_003C, 4'd0, 1'b0, 6'd8, 8'd1);
        watch_transfer(0, 30, 5, 32'h0000_00FF);
        $display("txn overrun: bits=0x%0h done_count=%0d overrun=%0b",
                 mon_bits, mon_done_count, overrun);
        check_value("ov_flag", overrun, 1);
        check_value("ov_bits", mon_bits, 64'h3C);
        check_value("ov_done_count", mon_done_count, 1);
        check_value("ov_done_cycle", mon_done_first, 19);
        clear_errors();
        check_value("ov_cleared", overrun, 0);

        // Strobe raised in the done cycle: back-to-back transfer
        issue(32'h0000_0005, 4'd0, 1'b0, 6'd3, 8'd1);
        watch_transfer(0, 25, 9, 32'h0000_0006);
        $display("txn b2b: bits=0x%0h n=%0d dones=%0d", mon_bits, mon_nbits, mon_done_count);
        check_value("b2b_first_done", mon_done_first, 9);
        check_value("b2b_busy_next", mon_busy_inj, 1);
        check_value("b2b_sdi_next", mon_sdi_inj, 1);
        check_value("b2b_bits", mon_bits, 64'h2E);
        check_value("b2b_done_count", mon_done_count, 2);
        check_value("b2b_no_overrun", overrun, 0);

        // Reset during HIGH phase of bit 3 (cycles 15..16 with D=2)
        issue(32'h0000_00A5, 4'd1, 1'b0, 6'd8, 8'd2);
        repeat (14) begin
            @(posedge sysClk);
            #1;
        end
        check_value("rst_in_high", spiClk[1], 1);
        #2 sysReset_n = 1'b0;
        #1;
        check_value("rst_async_outputs", {busy, done, spiClk, spiSdi, spiLe}, '0);
        @(negedge sysClk) sysReset_n = 1'b1;
        activity = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge sysClk);
            #1;
            if (busy || done) activity++;
        end
        $display("txn reset: post-release activity=%0d", activity);
        check_value("rst_no_done", activity, 0);
        issue(32'h0000_00A5, 4'd1, 1'b0, 6'd8, 8'd2);
        watch_transfer(1, 45, -10, '0);
        $display("txn after reset: bits=0x%0h done@%0d", mon_bits, mon_done_first);
        check_value("rst_next_bits", mon_bits, 64'hA5);
        check_value("rst_next_done", mon_done_first, 37);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
